ahb_lite_switch_n: RTL and testbench



---
 rtl/ahb_pkg.sv | 23 ++
 rtl/rr_arbiter_comb.sv | 38 +++
 rtl/ahb_lite_switch_n.sv | 115 +++++++++++
 tb/tb_ahb_lite_switch_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared types for the AHB-Lite switch and its arbiters.
//   HTRANS_state : AHB transfer type encoding
//   ARB_FIXED/RR : arbitration mode selectors
//   arb_state_t  : switch grant FSM states
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational N-way arbiter, fixed-priority or round-robin.
//   req   : request vector
//   ptr   : round-robin start index (ignored in fixed mode)
//   mode  : ARB_FIXED (lowest index wins) or ARB_RR (first at/after ptr)
//   win   : winning index, valid only when valid=1
//   valid : at least one request present
module rr_arbiter_comb
  import ahb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [IDX_W-1:0] win,
  output logic             valid
);

  always_comb begin
    int base;
    int idx;
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    base  = (mode == ARB_RR) ? int'(ptr) : 0;
    // Scan N slots starting at base; first hit wins.
    for (int i = 0; i < N; i++) begin
      idx = base + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_lite_switch_n.sv
// N-master AHB-Lite bus switch: grants the shared memory port to one master
// at a time by raising only that master's HREADY.
//   HCLK, HRESET  : clock, synchronous active-high reset
//   i_HTRANS      : per-master transfer type; NONSEQ is a request
//   i_slave_done  : per-master end-of-transaction pulse (owner's only counts)
//   o_HREADY      : one-hot or zero grant
//   o_grant_idx   : current owner, holds last value when idle
//   o_busy        : a grant is active
//   o_timeout     : one-cycle pulse when the watchdog revokes a grant
module ahb_lite_switch_n
  import ahb_pkg::*;
#(
  parameter int N_MASTERS      = 3,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_W          = $clog2(N_MASTERS)
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  HTRANS_state [N_MASTERS-1:0]   i_HTRANS,
  input  logic [N_MASTERS-1:0]          i_slave_done,
  output logic [N_MASTERS-1:0]          o_HREADY,
  output logic [IDX_W-1:0]              o_grant_idx,
  output logic                          o_busy,
  output logic                          o_timeout
);

  // Counter only needs to reach TIMEOUT_CYCLES; with the watchdog off it
  // just wraps harmlessly.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_MASTERS - 1);

  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;
  logic [CNT_W-1:0]     wd_cnt, cnt_nxt;
  logic [IDX_W-1:0]     grant_nxt;
  logic [N_MASTERS-1:0] hready_nxt;
  logic                 busy_nxt, timeout_nxt;

  logic [N_MASTERS-1:0] req;
  logic [IDX_W-1:0]     arb_win;
  logic                 arb_valid;
  logic                 done_own, wd_hit;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_req
    assign req[g] = (i_HTRANS[g] == NONSEQ);
  end

  rr_arbiter_comb #(.N(N_MASTERS), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .mode  ((ARB_MODE == 1) ? ARB_RR : ARB_FIXED),
    .win   (arb_win),
    .valid (arb_valid)
  );

  assign done_own = i_slave_done[o_grant_idx];
  assign wd_hit   = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = wd_cnt;
    grant_nxt   = o_grant_idx;
    hready_nxt  = o_HREADY;
    busy_nxt    = o_busy;
    timeout_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (arb_valid) begin
          state_nxt  = ARB_GRANT;
          grant_nxt  = arb_win;
          hready_nxt = N_MASTERS'(1) << arb_win;
          busy_nxt   = 1'b1;
          cnt_nxt    = CNT_W'(1);
        end
      end
      ARB_GRANT: begin
        if (done_own || wd_hit) begin
          state_nxt   = ARB_RELEASE;
          hready_nxt  = '0;
          busy_nxt    = 1'b0;
          // done wins over a coincident timeout
          timeout_nxt = !done_own;
          ptr_nxt     = (o_grant_idx == LAST) ? '0 : o_grant_idx + IDX_W'(1);
        end else begin
          cnt_nxt = wd_cnt + CNT_W'(1);
        end
      end
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      wd_cnt      <= '0;
      o_grant_idx <= '0;
      o_HREADY    <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      wd_cnt      <= cnt_nxt;
      o_grant_idx <= grant_nxt;
      o_HREADY    <= hready_nxt;
      o_busy      <= busy_nxt;
      o_timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_lite_switch_n.sv
// Bench for ahb_lite_switch_n: three instances (RR/T=8, fixed/T=8, RR/T=0)
// each compared every cycle against a transaction-level reference model.
module tb_ahb_lite_switch_n;
  import ahb_pkg::*;

  localparam int N = 3;
  localparam int MODE_K [3] = '{1, 0, 1};
  localparam int TMO_K  [3] = '{8, 8, 0};

  logic HCLK = 1'b0;
  logic rst  = 1'b1;
  always #5 HCLK = ~HCLK;

  HTRANS_state [N-1:0] htr [3];
  logic [N-1:0]        done [3];
  logic [N-1:0]        hr [3];
  logic [1:0]          gi [3];
  logic                bz [3];
  logic                to [3];

  ahb_lite_switch_n #(.N_MASTERS(N), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) u_d0 (
    .HCLK(HCLK), .HRESET(rst), .i_HTRANS(htr[0]), .i_slave_done(done[0]),
    .o_HREADY(hr[0]), .o_grant_idx(gi[0]), .o_busy(bz[0]), .o_timeout(to[0]));
  ahb_lite_switch_n #(.N_MASTERS(N), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) u_d1 (
    .HCLK(HCLK), .HRESET(rst), .i_HTRANS(htr[1]), .i_slave_done(done[1]),
    .o_HREADY(hr[1]), .o_grant_idx(gi[1]), .o_busy(bz[1]), .o_timeout(to[1]));
  ahb_lite_switch_n #(.N_MASTERS(N), .ARB_MODE(1), .TIMEOUT_CYCLES(0)) u_d2 (
    .HCLK(HCLK), .HRESET(rst), .i_HTRANS(htr[2]), .i_slave_done(done[2]),
    .o_HREADY(hr[2]), .o_grant_idx(gi[2]), .o_busy(bz[2]), .o_timeout(to[2]));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner (-1 = none), cycles held, dead cycles left.
  int m_owner [3], m_age [3], m_cool [3], m_ptr [3], m_last [3];
  bit m_tmo [3], m_new [3];
  int m_tcnt [3], o_tcnt [3];
  int seq [3][$];
  bit cap = 1'b0;

  function automatic logic [N-1:0] oh(input int o);
    return (o >= 0) ? N'(1 << o) : '0;
  endfunction

  task automatic model_reset(input int k);
    m_owner[k] = -1; m_age[k] = 0; m_cool[k] = 0; m_ptr[k] = 0; m_last[k] = 0;
  endtask

  task automatic model_step(input int k);
    m_tmo[k] = 1'b0;
    m_new[k] = 1'b0;
    if (rst) model_reset(k);
    else if (m_owner[k] >= 0) begin
      if (done[k][m_owner[k]] || (TMO_K[k] != 0 && m_age[k] == TMO_K[k])) begin
        m_tmo[k]   = !done[k][m_owner[k]];
        m_ptr[k]   = (m_owner[k] + 1) % N;
        m_owner[k] = -1;
        m_cool[k]  = 1;
      end else m_age[k]++;
    end else if (m_cool[k] > 0) m_cool[k]--;
    else begin
      for (int j = 0; j < N; j++) begin
        int c;
        c = ((MODE_K[k] == 1 ? m_ptr[k] : 0) + j) % N;
        if (m_owner[k] < 0 && htr[k][c] == NONSEQ) begin
          m_owner[k] = c; m_age[k] = 1; m_last[k] = c; m_new[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge HCLK);
    @(negedge HCLK);
    for (int k = 0; k < 3; k++) begin
      model_step(k);
      chk($sformatf("d%0d_hready", k), 32'(hr[k]), 32'(oh(m_owner[k])));
      chk($sformatf("d%0d_busy", k), 32'(bz[k]), 32'(m_owner[k] >= 0));
      chk($sformatf("d%0d_idx", k), 32'(gi[k]), 32'(m_last[k]));
      chk($sformatf("d%0d_timeout", k), 32'(to[k]), 32'(m_tmo[k]));
      chk($sformatf("d%0d_onehot0", k), 32'($onehot0(hr[k])), 32'd1);
      m_tcnt[k] += int'(m_tmo[k]);
      o_tcnt[k] += int'(to[k]);
      if (cap && m_new[k]) seq[k].push_back(int'(gi[k]));
    end
  endtask

  task automatic set_all(input HTRANS_state t);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) htr[k][i] = t;
      done[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; set_all(IDLE); cycle(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int k = 0; k < 3; k++) begin
      model_reset(k); m_tcnt[k] = 0; o_tcnt[k] = 0;
    end
    set_all(IDLE);
    cycle(); cycle();
    chk("rst_hready", 32'(hr[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    rst = 1'b0;
    cycle();

    // single request from master 1, then done
    for (int k = 0; k < 3; k++) htr[k][1] = NONSEQ;
    cycle();
    set_all(IDLE);
    chk("single_hready", 32'(hr[0]), 32'b010);
    chk("single_idx", 32'(gi[0]), 32'd1);
    chk("single_busy", 32'(bz[0]), 32'd1);
    cycle(); cycle(); cycle();
    for (int k = 0; k < 3; k++) done[k] = 3'b010;
    cycle();
    set_all(IDLE);
    chk("single_release", 32'(hr[0]), 32'd0);
    cycle(); cycle();

    // fairness: everyone requests, owner finishes on its 4th grant cycle
    do_reset();
    cap = 1'b1;
    set_all(NONSEQ);
    for (int c = 0; c < 120 && seq[0].size() < 6; c++) begin
      cycle();
      for (int k = 0; k < 3; k++)
        done[k] = (m_owner[k] >= 0 && m_age[k] == 4) ? oh(m_owner[k]) : '0;
    end
    cap = 1'b0;
    chk("fair_count", 32'(seq[0].size()), 32'd6);
    for (int j = 0; j < 6 && j < seq[0].size(); j++) begin
      chk($sformatf("rr_order%0d", j), 32'(seq[0][j]), 32'(j % 3));
      if (j < seq[2].size()) chk($sformatf("rr0_order%0d", j), 32'(seq[2][j]), 32'(j % 3));
      if (j < seq[1].size()) chk($sformatf("fixed_order%0d", j), 32'(seq[1][j]), 32'd0);
    end

    // hold: master 2 never finishes; T=8 revokes, T=0 keeps it
    do_reset();
    set_all(IDLE);
    for (int k = 0; k < 3; k++) htr[k][2] = NONSEQ;
    t0 = o_tcnt[0];
    for (int c = 0; c < 40; c++) cycle();
    chk("hold_t0_hready", 32'(hr[2]), 32'b100);
    chk("hold_t0_idx", 32'(gi[2]), 32'd2);
    chk("hold_t8_pulses", 32'(o_tcnt[0] - t0), 32'd4);

    // done coincident with timeout, plus done noise from non-owners
    do_reset();
    set_all(IDLE);
    for (int k = 0; k < 3; k++) begin htr[k][2] = NONSEQ; htr[k][0] = NONSEQ; end
    t0 = o_tcnt[0];
    for (int c = 0; c < 40; c++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        done[k] = N'($urandom_range(0, 7)) & ~oh(m_owner[k]);
        if (m_owner[k] >= 0 && m_age[k] == (TMO_K[k] != 0 ? TMO_K[k] : 5))
          done[k] = done[k] | oh(m_owner[k]);
      end
    end
    chk("edge_no_timeout", 32'(o_tcnt[0] - t0), 32'd0);

    // reset in the middle of a grant to master 1
    do_reset();
    set_all(IDLE);
    for (int k = 0; k < 3; k++) htr[k][1] = NONSEQ;
    cycle(); cycle();
    chk("mid_pre_idx", 32'(gi[0]), 32'd1);
    rst = 1'b1;
    cycle();
    chk("mid_hready", 32'(hr[0]), 32'd0);
    chk("mid_idx", 32'(gi[0]), 32'd0);
    chk("mid_timeout", 32'(to[0]), 32'd0);
    rst = 1'b0;
    set_all(NONSEQ);
    cycle();
    chk("post_rst_first", 32'(hr[0]), 32'b001);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < N; i++) begin
          logic [1:0] r;
          r = $urandom_range(0, 1) ? 2'b10 : 2'($urandom_range(0, 3));
          htr[k][i] = HTRANS_state'(r);
          done[k][i] = ($urandom_range(0, 9) == 0);
        end
      end
      cycle();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("d%0d_tmo_total", k), 32'(o_tcnt[k]), 32'(m_tcnt[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
